// File: rtl/core_rf_sr_stack_pkg.sv
// Shared SR definitions: field order {i, mode, flag}, default widths,
// field offsets and the packed SR type for the default configuration.
package i2d_core_defines;

    localparam int SR_FLAG_W   = 4;
    localparam int SR_MODE_W   = 2;
    localparam int SR_W        = SR_FLAG_W + SR_MODE_W + 1;

    localparam int SR_FLAG_LSB = 0;
    localparam int SR_MODE_LSB = SR_FLAG_W;
    localparam int SR_I_BIT    = SR_FLAG_W + SR_MODE_W;

    typedef struct packed {
        logic                 i;
        logic [SR_MODE_W-1:0] mode;
        logic [SR_FLAG_W-1:0] flag;
    } sr_t;

    // Build a default-configuration SR value from its fields.
    function automatic sr_t sr_pack(input logic i_v,
                                    input logic [SR_MODE_W-1:0] mode_v,
                                    input logic [SR_FLAG_W-1:0] flag_v);
        sr_t r;
        r.i    = i_v;
        r.mode = mode_v;
        r.flag = flag_v;
        return r;
    endfunction

endpackage

// File: rtl/core_sr_lifo.sv
// Save-slot LIFO for SR values. Push at full and pop at empty are ignored
// and reported on err in the same cycle. Storage itself is never reset;
// slots above depth are stale by design.
module core_sr_lifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    logic [IW-1:0]    wr_idx, rd_idx;

    // Accepted operations, occupancy update and overflow/underflow report.
    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !push && !empty_q;
        err     = (push && full_q) || (pop && !push && empty_q);
        wr_idx  = IW'(depth_q);
        rd_idx  = IW'(depth_q - DW'(1));
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end
        full_d  = (depth_d == DW'(DEPTH));
        empty_d = (depth_d == '0);
    end

    // Occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            depth_q <= depth_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Slot storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign dout  = mem_q[rd_idx];
    assign depth = depth_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/core_rf_sr_stack.sv
// Architectural status register {i, mode, flag} with a save stack for nested
// exception entry/return. Priority: exc_enter > exc_return > field writes.
module core_rf_sr_stack
    import i2d_core_defines::*;
#(
    parameter int FLAG_W     = SR_FLAG_W,
    parameter int MODE_W     = SR_MODE_W,
    parameter int DEPTH      = 4,
    parameter int RESET_MODE = 0,
    localparam int SRW       = FLAG_W + MODE_W + 1,
    localparam int DW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] flag,
    input  logic              flag_we,
    input  logic              write_sr,
    input  logic [SRW-1:0]    sr_in,
    input  logic              write_mode,
    input  logic [MODE_W-1:0] mode,
    input  logic              write_i,
    input  logic              i,
    input  logic              exc_enter,
    input  logic [MODE_W-1:0] exc_mode,
    input  logic              exc_return,
    output logic [SRW-1:0]    sr,
    output logic [DW-1:0]     depth,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              nest_err
);

    localparam int MODE_LSB = FLAG_W;
    localparam int I_BIT    = FLAG_W + MODE_W;

    logic [SRW-1:0] sr_q, sr_d;
    logic           nest_err_q, nest_err_d;
    logic [SRW-1:0] n_sr;
    logic           lifo_push, lifo_pop, lifo_err;
    logic [SRW-1:0] lifo_dout;

    // Normal-path value and priority mux for the next SR.
    always_comb begin
        if (write_sr) begin
            n_sr = sr_in;
        end else begin
            n_sr = {write_i    ? i    : sr_q[I_BIT],
                    write_mode ? mode : sr_q[I_BIT-1:MODE_LSB],
                    flag_we    ? flag : sr_q[FLAG_W-1:0]};
        end

        // A simultaneous return is dropped, so it never reaches the stack.
        lifo_push = exc_enter;
        lifo_pop  = exc_return && !exc_enter;

        sr_d = n_sr;
        if (exc_enter) begin
            sr_d = {1'b0, exc_mode, n_sr[FLAG_W-1:0]};
        end else if (exc_return && !stack_empty) begin
            sr_d = lifo_dout;
        end
        nest_err_d = lifo_err;
    end

    // SR and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= {1'b0, MODE_W'(RESET_MODE), {FLAG_W{1'b0}}};
            nest_err_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            nest_err_q <= nest_err_d;
        end
    end

    core_sr_lifo #(
        .WIDTH (SRW),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .din   (n_sr),
        .dout  (lifo_dout),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty),
        .err   (lifo_err)
    );

    assign sr       = sr_q;
    assign nest_err = nest_err_q;

endmodule

// File: tb/tb_core_rf_sr_stack.sv
// Directed bench for core_rf_sr_stack with FLAG_W=4, MODE_W=2, DEPTH=2.
module tb_core_rf_sr_stack;
    import i2d_core_defines::*;

    localparam int FLAG_W = 4;
    localparam int MODE_W = 2;
    localparam int DEPTH  = 2;
    localparam int SRW    = 7;
    localparam int DW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLAG_W-1:0] flag;
    logic              flag_we;
    logic              write_sr;
    logic [SRW-1:0]    sr_in;
    logic              write_mode;
    logic [MODE_W-1:0] mode;
    logic              write_i;
    logic              i;
    logic              exc_enter;
    logic [MODE_W-1:0] exc_mode;
    logic              exc_return;
    logic [SRW-1:0]    sr;
    logic [DW-1:0]     depth;
    logic              stack_full;
    logic              stack_empty;
    logic              nest_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    core_rf_sr_stack #(
        .FLAG_W     (FLAG_W),
        .MODE_W     (MODE_W),
        .DEPTH      (DEPTH),
        .RESET_MODE (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flag        (flag),
        .flag_we     (flag_we),
        .write_sr    (write_sr),
        .sr_in       (sr_in),
        .write_mode  (write_mode),
        .mode        (mode),
        .write_i     (write_i),
        .i           (i),
        .exc_enter   (exc_enter),
        .exc_mode    (exc_mode),
        .exc_return  (exc_return),
        .sr          (sr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .nest_err    (nest_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 1'b0; flag = '0; flag_we = 1'b0; write_sr = 1'b0; sr_in = '0;
        write_mode = 1'b0; mode = '0; write_i = 1'b0; i = 1'b0;
        exc_enter = 1'b0; exc_mode = '0; exc_return = 1'b0;
    endtask

    // One clock with the currently driven inputs, then return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; flag = 4'($urandom); flag_we = 1'b1; write_sr = 1'b1;
        sr_in = 7'($urandom); write_mode = 1'b1; mode = 2'($urandom);
        write_i = 1'b1; i = 1'b1; exc_enter = 1'b1; exc_mode = 2'($urandom);
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h00) $display("FAIL reset_sr got %h want %h", sr, 7'h00); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL reset_depth got %0d want 0", depth); else pass_cnt++;
        total_cnt++; if (stack_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", stack_empty); else pass_cnt++;
        total_cnt++; if (stack_full !== 1'b0) $display("FAIL reset_full got %b want 0", stack_full); else pass_cnt++;
        total_cnt++; if (nest_err !== 1'b0) $display("FAIL reset_nest_err got %b want 0", nest_err); else pass_cnt++;
    endtask

    task automatic test_field_writes();
        flag_we = 1'b1; flag = 4'hA; write_mode = 1'b1; mode = 2'd2; write_i = 1'b1; i = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h6A) $display("FAIL field_write got %h want %h", sr, 7'h6A); else pass_cnt++;
        write_sr = 1'b1; sr_in = sr_pack(1'b0, 2'd1, 4'h5); flag_we = 1'b1; flag = 4'hF;
        step();
        total_cnt++; if (sr !== 7'h15) $display("FAIL write_sr_override got %h want %h", sr, 7'h15); else pass_cnt++;
        write_sr = 1'b1; sr_in = 7'h6A;
        step();
        total_cnt++; if (sr !== 7'h6A) $display("FAIL write_sr_full got %h want %h", sr, 7'h6A); else pass_cnt++;
    endtask

    task automatic test_nesting();
        exc_enter = 1'b1; exc_mode = 2'd3;
        step();
        total_cnt++; if (sr !== 7'h3A) $display("FAIL nest_enter1_sr got %h want %h", sr, 7'h3A); else pass_cnt++;
        total_cnt++; if (depth !== 2'd1) $display("FAIL nest_enter1_depth got %0d want 1", depth); else pass_cnt++;
        exc_enter = 1'b1; exc_mode = 2'd1;
        step();
        total_cnt++; if (sr !== 7'h1A) $display("FAIL nest_enter2_sr got %h want %h", sr, 7'h1A); else pass_cnt++;
        total_cnt++; if (depth !== 2'd2) $display("FAIL nest_enter2_depth got %0d want 2", depth); else pass_cnt++;
        total_cnt++; if (stack_full !== 1'b1) $display("FAIL nest_full got %b want 1", stack_full); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h3A) $display("FAIL nest_ret1_sr got %h want %h", sr, 7'h3A); else pass_cnt++;
        total_cnt++; if (stack_full !== 1'b0) $display("FAIL nest_ret1_full got %b want 0", stack_full); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h6A) $display("FAIL nest_ret2_sr got %h want %h", sr, 7'h6A); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL nest_ret2_depth got %0d want 0", depth); else pass_cnt++;
        total_cnt++; if (stack_empty !== 1'b1) $display("FAIL nest_ret2_empty got %b want 1", stack_empty); else pass_cnt++;
        total_cnt++; if (nest_err !== 1'b0) $display("FAIL nest_no_err got %b want 0", nest_err); else pass_cnt++;
    endtask

    task automatic test_overflow();
        exc_enter = 1'b1; exc_mode = 2'd3; step();
        exc_enter = 1'b1; exc_mode = 2'd1; step();
        exc_enter = 1'b1; exc_mode = 2'd2;
        step();
        total_cnt++; if (nest_err !== 1'b1) $display("FAIL ovf_err got %b want 1", nest_err); else pass_cnt++;
        total_cnt++; if (depth !== 2'd2) $display("FAIL ovf_depth got %0d want 2", depth); else pass_cnt++;
        total_cnt++; if (sr !== 7'h2A) $display("FAIL ovf_sr got %h want %h", sr, 7'h2A); else pass_cnt++;
        step();
        total_cnt++; if (nest_err !== 1'b0) $display("FAIL ovf_pulse_width got %b want 0", nest_err); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h3A) $display("FAIL ovf_ret1_sr got %h want %h", sr, 7'h3A); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h6A) $display("FAIL ovf_ret2_sr got %h want %h", sr, 7'h6A); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL ovf_ret2_depth got %0d want 0", depth); else pass_cnt++;
    endtask

    task automatic test_underflow_conflict();
        exc_return = 1'b1; flag_we = 1'b1; flag = 4'h3;
        step();
        total_cnt++; if (nest_err !== 1'b1) $display("FAIL unf_err got %b want 1", nest_err); else pass_cnt++;
        total_cnt++; if (sr !== 7'h63) $display("FAIL unf_sr got %h want %h", sr, 7'h63); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL unf_depth got %0d want 0", depth); else pass_cnt++;
        step();
        total_cnt++; if (nest_err !== 1'b0) $display("FAIL unf_pulse_width got %b want 0", nest_err); else pass_cnt++;
        exc_enter = 1'b1; exc_mode = 2'd1; exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h13) $display("FAIL conflict_sr got %h want %h", sr, 7'h13); else pass_cnt++;
        total_cnt++; if (depth !== 2'd1) $display("FAIL conflict_depth got %0d want 1", depth); else pass_cnt++;
        total_cnt++; if (nest_err !== 1'b0) $display("FAIL conflict_err got %b want 0", nest_err); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (sr !== 7'h63) $display("FAIL conflict_ret_sr got %h want %h", sr, 7'h63); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        exc_enter = 1'b1; exc_mode = 2'd3; step();
        exc_enter = 1'b1; exc_mode = 2'd1; step();
        total_cnt++; if (depth !== 2'd2) $display("FAIL mid_pre_depth got %0d want 2", depth); else pass_cnt++;
        rst = 1'b1; exc_enter = 1'b1; exc_mode = 2'd2;
        step();
        total_cnt++; if (sr !== 7'h00) $display("FAIL mid_rst_sr got %h want %h", sr, 7'h00); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL mid_rst_depth got %0d want 0", depth); else pass_cnt++;
        total_cnt++; if (stack_empty !== 1'b1) $display("FAIL mid_rst_empty got %b want 1", stack_empty); else pass_cnt++;
        exc_return = 1'b1;
        step();
        total_cnt++; if (nest_err !== 1'b1) $display("FAIL mid_unf_err got %b want 1", nest_err); else pass_cnt++;
        total_cnt++; if (depth !== 2'd0) $display("FAIL mid_unf_depth got %0d want 0", depth); else pass_cnt++;
        total_cnt++; if (sr !== 7'h00) $display("FAIL mid_unf_sr got %h want %h", sr, 7'h00); else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_field_writes();
        test_nesting();
        test_overflow();
        test_underflow_conflict();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/core_rf_sr_stack.md
Name: core_rf_sr_stack

Overview:
- Parametrised status register (flags, mode, interrupt enable) with a hardware LIFO of saved SR values for nested exception entry and return.
- Sits in the core register-file stage.
  - Takes per-instruction flag updates from the ALU.
  - Takes explicit SR, mode and I writes from the decoder/CSR path.
  - Takes exception enter/return strobes from the control unit.
- Drives the architectural SR every cycle.

Parameters:
- FLAG_W, 4, number of condition flag bits.
- MODE_W, 2, width of the privilege/mode field.
- DEPTH, 4, number of SR save slots (max exception nesting); must be >= 1.
- RESET_MODE, 0, mode value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flag  in  FLAG_W  new flag value from ALU.
- flag_we  in  1  load flag field from flag.
- write_sr  in  1  load entire SR from sr_in.
- sr_in  in  SR_W  full SR value (SR_W = FLAG_W+MODE_W+1).
- write_mode  in  1  load mode field from mode.
- mode  in  MODE_W  new mode value.
- write_i  in  1  load I bit from i.
- i  in  1  new interrupt-enable value.
- exc_enter  in  1  exception/interrupt entry strobe.
- exc_mode  in  MODE_W  mode to enter on exc_enter.
- exc_return  in  1  exception return strobe.
- sr  out  SR_W  current SR, packed {i, mode, flag}, registered.
- depth  out  $clog2(DEPTH+1)  number of occupied save slots.
- stack_full  out  1  depth == DEPTH.
- stack_empty  out  1  depth == 0.
- nest_err  out  1  one-cycle pulse on overflow or underflow.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - sr = {i=0, mode=RESET_MODE, flag=0}.
  - depth = 0, stack_full = 0, stack_empty = 1, nest_err = 0.
  - Stack storage is not reset. Contents above depth are don't-care.
- rst has priority over all other inputs in the same cycle.
- Latency: every update is visible on sr/depth the cycle after the strobe edge. No combinational path from inputs to outputs.
- Normal path value N, computed each cycle:
  - If write_sr: N = sr_in.
  - Else, per field:
    - flag = flag_we ? flag : sr.flag
    - mode = write_mode ? mode : sr.mode
    - i = write_i ? i : sr.i
  - write_sr overrides field writes in the same cycle.
- Priority: exc_enter > exc_return > normal path. Only one action is taken per cycle.
- exc_enter:
  - Push N (preserves the completing instruction's effects).
  - Next sr = {i=0, mode=exc_mode, flag=N.flag}.
  - depth+1.
- exc_enter when stack_full:
  - No push; depth unchanged; sr still switches as above.
  - nest_err = 1 for one cycle.
- exc_return:
  - Next sr = top entry; depth-1.
  - Normal-path inputs that cycle are discarded.
- exc_return when stack_empty:
  - sr = N; depth stays 0.
  - nest_err = 1 for one cycle.
- exc_enter and exc_return in the same cycle: enter only; return is dropped silently with no nest_err.
- stack_full/stack_empty are registered and consistent with depth in the same cycle.
- Reset mid-nesting discards all saved entries (depth=0).

Decomposition:
- Shared package (i2d_core_defines): SR field order {i, mode, flag}, default FLAG_W/MODE_W constants, field-offset localparams, and the sr_t typedef for the default configuration.
- One sub-module, core_sr_lifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/din/dout/depth/full/empty.
  - Push at full and pop at empty are ignored internally and flagged.
- Top level holds the SR register, the priority mux and nest_err generation.

Test Plan (FLAG_W=4, MODE_W=2, DEPTH=2, RESET_MODE=0):
1. Reset: assert rst 1 cycle with random inputs -> sr=7'h00, depth=0, stack_empty=1, stack_full=0, nest_err=0.
2. Field writes: flag_we=1 flag=4'hA, write_mode=1 mode=2, write_i=1 i=1 -> next cycle sr={1,2,A}. Then write_sr=1 sr_in={0,1,5} with flag_we=1 flag=F -> sr={0,1,5}.
3. Nesting: from sr={1,2,A}:
   - exc_enter exc_mode=3 -> sr={0,3,A}, depth=1.
   - exc_enter exc_mode=1 -> sr={0,1,A}, depth=2, full=1.
   - exc_return x2 -> sr={0,3,A}, then {1,2,A}; depth 0, empty=1.
4. Overflow: at depth=2, exc_enter exc_mode=2 -> nest_err pulse 1 cycle, depth=2, sr.mode=2, sr.i=0. Subsequent returns restore the two originally saved values.
5. Underflow and conflicts:
   - exc_return at depth=0 with flag_we=1 flag=3 -> nest_err pulse, sr.flag=3, depth=0.
   - exc_enter+exc_return together -> enter only, depth+1, no nest_err.
6. Reset mid-operation: depth=2, rst=1 -> sr reset, depth=0. Next exc_return -> nest_err pulse.
